// File: rtl/spart_fifo_if.sv
// ---------------------------------------------------------------------------
// spart_fifo_if
// Processor-side handshake of the buffered SPART.
//   iocs   : chip select. It qualifies every access.
//   iorw   : 1 = read, 0 = write.
//   ioaddr : register select.
//   rda    : RX FIFO holds at least one byte.
//   tbr    : TX FIFO has room for a write.
// The 8-bit tri-state data bus stays a plain inout port on the SPART. A
// resolved tri-state net is kept off the interface so that the two drivers
// (CPU and SPART) meet on an ordinary module-level wire.
// ---------------------------------------------------------------------------
interface spart_fifo_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input  rda, tbr);
  modport slave  (input  iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_fifo.sv
// ---------------------------------------------------------------------------
// spart_fifo
// Buffered SPART with TX/RX FIFOs, a programmable baud divisor and sticky
// line-error flags.
// Ports:
//   clk     : system clock.
//   rst     : asynchronous, active-high reset.
//   bus     : spart_fifo_if.slave (iocs/iorw/ioaddr in, rda/tbr out).
//   databus : 8-bit tri-state CPU data bus. It is driven only while iocs & iorw.
//   txd     : serial output. It idles high.
//   rxd     : serial input. It is asynchronous to clk.
// Register map:
//   00 : RX pop / TX push
//   01 : status (read only)
//   10 : divisor low byte
//   11 : divisor high byte
// Optional feature:
//   Defining SPART_PARITY_EN adds an even-parity bit after D7, giving 8E1
//   frames. Left undefined, the block handles 8N1 frames only.
// ---------------------------------------------------------------------------
module spart_fifo #(
  parameter int          RX_DEPTH   = 16,
  parameter int          TX_DEPTH   = 16,
  parameter int          OVERSAMPLE = 16,
  parameter logic [15:0] DIV_RESET  = 16'd162
) (
  input  logic        clk,
  input  logic        rst,
  spart_fifo_if.slave bus,
  inout  wire  [7:0]  databus,
  output logic        txd,
  input  logic        rxd
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
`ifdef SPART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam logic [15:0] OS_LAST = 16'(OVERSAMPLE - 1);
  localparam logic [15:0] OS_HALF = 16'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  // ---------------- bus decode ----------------
  logic w_rd, w_wr, w_stat_rd;
  assign w_rd      = bus.iocs &  bus.iorw;
  assign w_wr      = bus.iocs & ~bus.iorw;
  assign w_stat_rd = w_rd && (bus.ioaddr == 2'b01);

  // ---------------- divisor and baud tick ----------------
  logic [15:0] r_div, r_baud_cnt;
  logic        w_tick;
  assign w_tick = (r_baud_cnt == 16'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= DIV_RESET;
      r_baud_cnt <= DIV_RESET;
    end else if (w_wr && bus.ioaddr == 2'b10) begin
      r_div[7:0] <= databus;
      r_baud_cnt <= {r_div[15:8], databus};
    end else if (w_wr && bus.ioaddr == 2'b11) begin
      r_div[15:8] <= databus;
      r_baud_cnt  <= {databus, r_div[7:0]};
    end else if (w_tick) begin
      r_baud_cnt <= r_div;
    end else begin
      r_baud_cnt <= r_baud_cnt - 16'd1;
    end
  end

  // ---------------- TX FIFO ----------------
  // The byte being sent stays in the FIFO until its stop bit ends. This way
  // tbr accounts for the frame in flight, and TX_DEPTH writes fill the path.
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [TX_AW:0] r_tx_wr, r_tx_rd, w_tx_count;
  logic           w_tx_empty, w_tx_full, w_tx_more, w_tx_push, w_tx_pop;
  assign w_tx_count = r_tx_wr - r_tx_rd;
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[TX_AW] != r_tx_rd[TX_AW]) &&
                      (r_tx_wr[TX_AW-1:0] == r_tx_rd[TX_AW-1:0]);
  assign w_tx_more  = (w_tx_count > (TX_AW+1)'(1));
  assign w_tx_push  = w_wr && (bus.ioaddr == 2'b00) && !w_tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + (TX_AW+1)'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + (TX_AW+1)'(1);
    end
  end

  // NOTE: storage arrays carry no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= databus;
  end

  // ---------------- TX shifter ----------------
  function automatic logic [FRAME_BITS-1:0] tx_frame(input logic [7:0] d);
`ifdef SPART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  logic [FRAME_BITS-1:0] r_tx_sr;
  logic                  r_tx_busy, r_tx_active;
  logic [15:0]           r_tx_os;
  logic [3:0]            r_tx_bits;

  assign w_tx_pop = r_tx_busy && r_tx_active && w_tick &&
                    (r_tx_os == OS_LAST) && (r_tx_bits == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_sr     <= '1;
      r_tx_busy   <= 1'b0;
      r_tx_active <= 1'b0;
      r_tx_os     <= '0;
      r_tx_bits   <= '0;
    end else if (!r_tx_busy) begin
      if (!w_tx_empty) begin
        r_tx_sr     <= tx_frame(r_tx_mem[r_tx_rd[TX_AW-1:0]]);
        r_tx_busy   <= 1'b1;
        r_tx_active <= 1'b0;
      end
    end else if (w_tick) begin
      if (!r_tx_active) begin
        // A loaded frame waits for the next tick to start its start bit.
        r_tx_active <= 1'b1;
        r_tx_os     <= '0;
        r_tx_bits   <= 4'(FRAME_BITS);
      end else if (r_tx_os != OS_LAST) begin
        r_tx_os <= r_tx_os + 16'd1;
      end else begin
        r_tx_os <= '0;
        if (r_tx_bits != 4'd1) begin
          r_tx_sr   <= r_tx_sr >> 1;
          r_tx_bits <= r_tx_bits - 4'd1;
        end else if (w_tx_more) begin
          // Chain the next byte onto this stop-bit edge, leaving no idle gap.
          r_tx_sr   <= tx_frame(r_tx_mem[r_tx_rd[TX_AW-1:0] + TX_AW'(1)]);
          r_tx_bits <= 4'(FRAME_BITS);
        end else begin
          r_tx_busy   <= 1'b0;
          r_tx_active <= 1'b0;
        end
      end
    end
  end

  assign txd = r_tx_active ? r_tx_sr[0] : 1'b1;

  // ---------------- RX synchroniser and FSM ----------------
  logic [1:0] r_rx_sync;
  logic       r_rx_prev, w_rx;
  assign w_rx = r_rx_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rxd};
      r_rx_prev <= w_rx;
    end
  end

  rx_state_t   r_rx_state, w_rx_next;
  logic [15:0] r_rx_os;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_push, w_rx_half, w_rx_bit_tick, w_rx_good, w_rx_ferr;
  assign w_rx_half     = w_tick && (r_rx_os == OS_HALF);
  assign w_rx_bit_tick = w_tick && (r_rx_os == OS_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_good = 1'b0;
    w_rx_ferr = 1'b0;
    unique case (r_rx_state)
      RX_IDLE:   if (r_rx_prev && !w_rx) w_rx_next = RX_START;
      RX_START:  if (w_rx_half) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (w_rx_bit_tick && r_rx_bit == 3'd7)
`ifdef SPART_PARITY_EN
          w_rx_next = RX_PARITY;
`else
          w_rx_next = RX_STOP;
`endif
      RX_PARITY: if (w_rx_bit_tick) w_rx_next = RX_STOP;
      RX_STOP:
        if (w_rx_bit_tick) begin
          if (w_rx) begin
            w_rx_next = RX_IDLE;
            w_rx_good = 1'b1;
          end else begin
            w_rx_next = RX_BREAK;
            w_rx_ferr = 1'b1;
          end
        end
      RX_BREAK:  if (w_rx) w_rx_next = RX_IDLE;   // wait out a low stop bit
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_os    <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_push  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_push  <= w_rx_good;
      // Tick phase restarts on every state change and every bit sample.
      if (r_rx_state != w_rx_next || w_rx_bit_tick) r_rx_os <= '0;
      else if (w_tick)                              r_rx_os <= r_rx_os + 16'd1;
      if (r_rx_state == RX_START) r_rx_bit <= '0;
      if (r_rx_state == RX_DATA && w_rx_bit_tick) begin
        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [RX_AW:0] r_rx_wr, r_rx_rd;
  logic           w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_ovr;
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[RX_AW] != r_rx_rd[RX_AW]) &&
                      (r_rx_wr[RX_AW-1:0] == r_rx_rd[RX_AW-1:0]);
  assign w_rx_pop   = w_rd && (bus.ioaddr == 2'b00) && !w_rx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_rx_push  = r_rx_push && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr   = r_rx_push &&  w_rx_full && !w_rx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + (RX_AW+1)'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + (RX_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= r_rx_shift;
  end

  // ---------------- sticky flags ----------------
  // A new event in the same cycle as the clearing read wins, so it is not lost.
  logic r_ovr, r_ferr, w_perr_flag;
`ifdef SPART_PARITY_EN
  logic r_rx_par, r_perr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_par <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      if (r_rx_state == RX_PARITY && w_rx_bit_tick) r_rx_par <= w_rx;
      r_perr <= (r_perr & ~w_stat_rd) | (w_rx_good & (^r_rx_shift ^ r_rx_par));
    end
  end
  assign w_perr_flag = r_perr;
`else
  assign w_perr_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= (r_ovr  & ~w_stat_rd) | w_rx_ovr;
      r_ferr <= (r_ferr & ~w_stat_rd) | w_rx_ferr;
    end
  end

  // ---------------- outputs and read mux ----------------
  logic [7:0] w_status, w_rdata;
  assign bus.rda  = !w_rx_empty;
  assign bus.tbr  = !w_tx_full;
  assign w_status = {1'b0, w_perr_flag, r_ferr, r_ovr, w_rx_full,
                     (w_tx_empty && !r_tx_busy), !w_tx_full, !w_rx_empty};

  always_comb begin
    w_rdata = 8'h00;
    unique case (bus.ioaddr)
      2'b00:   w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd[RX_AW-1:0]];
      2'b01:   w_rdata = w_status;
      2'b10:   w_rdata = r_div[7:0];
      default: w_rdata = r_div[15:8];
    endcase
  end

  assign databus = w_rd ? w_rdata : 8'hzz;
endmodule

// File: tb/tb_spart_fifo.sv
// ---------------------------------------------------------------------------
// tb_spart_fifo
// Directed bench for spart_fifo. A register table covers reset values and
// divisor access. Hand-written sequences cover reset mid-frame, loopback,
// TX overflow, RX overrun, framing, glitch rejection and parity.
// ---------------------------------------------------------------------------
module tb_spart_fifo;
  localparam int DEPTH = 16;
  localparam int OS    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       txd, rxd, tb_rxd, loop_en;
  logic [7:0] tb_wdata;
  logic       tb_drive;
  wire  [7:0] databus;

  int n_checks = 0;
  int n_errors = 0;

  assign databus = tb_drive ? tb_wdata : 8'hzz;
  assign rxd     = loop_en ? txd : tb_rxd;

  spart_fifo_if bus ();

  spart_fifo #(
    .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .OVERSAMPLE(OS), .DIV_RESET(16'd162)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .databus(databus), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; tb_wdata = d; tb_drive = 1'b1;
    @(negedge clk);
    bus.iocs = 1'b0; tb_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(name, {24'd0, d}, {24'd0, exp});
  endtask

  // Drive n bits LSB first on rxd, one bit per period clocks, then idle high.
  task automatic send_bits(input logic [10:0] bits, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      tb_rxd = bits[i];
      repeat (period) @(negedge clk);
    end
    tb_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int period);
`ifdef SPART_PARITY_EN
    send_bits({stop, ^d, d, 1'b0}, 11, period);
`else
    send_bits({1'b0, stop, d, 1'b0}, 10, period);
`endif
  endtask

  // Capture one frame from txd. ok = 0 if the start never comes or bits are wrong.
  task automatic tx_capture(input int period, output logic [7:0] d, output bit ok);
    int t;
    ok = 1'b0; d = 8'h00; t = 0;
    while (txd !== 1'b0 && t < 30 * period) begin
      @(negedge clk); t++;
    end
    if (txd !== 1'b0) return;
    repeat (period / 2) @(negedge clk);
    if (txd !== 1'b0) return;
    for (int b = 0; b < 8; b++) begin
      repeat (period) @(negedge clk);
      d[b] = txd;
    end
`ifdef SPART_PARITY_EN
    repeat (period) @(negedge clk);
    if (txd !== ^d) return;
`endif
    repeat (period) @(negedge clk);
    if (txd !== 1'b1) return;
    ok = 1'b1;
  endtask

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;   // write data, or expected read data
    string      name;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [7:0] d;
    bit         ok;
    int         t, lows;

    vecs[0]  = '{1'b0, 2'b01, 8'h06, "status_reset"};
    vecs[1]  = '{1'b0, 2'b10, 8'hA2, "div_lo_reset"};
    vecs[2]  = '{1'b0, 2'b11, 8'h00, "div_hi_reset"};
    vecs[3]  = '{1'b0, 2'b00, 8'h00, "rx_empty_read"};
    vecs[4]  = '{1'b1, 2'b01, 8'hFF, "status_write"};
    vecs[5]  = '{1'b0, 2'b01, 8'h06, "status_write_ignored"};
    vecs[6]  = '{1'b1, 2'b10, 8'h34, "div_lo_wr"};
    vecs[7]  = '{1'b0, 2'b10, 8'h34, "div_lo_rd"};
    vecs[8]  = '{1'b1, 2'b11, 8'h12, "div_hi_wr"};
    vecs[9]  = '{1'b0, 2'b11, 8'h12, "div_hi_rd"};
    vecs[10] = '{1'b0, 2'b10, 8'h34, "div_lo_kept"};
    vecs[11] = '{1'b1, 2'b10, 8'h03, "div_lo_wr3"};
    vecs[12] = '{1'b1, 2'b11, 8'h00, "div_hi_wr0"};
    vecs[13] = '{1'b0, 2'b10, 8'h03, "div_lo_rd3"};
    vecs[14] = '{1'b0, 2'b11, 8'h00, "div_hi_rd0"};

    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
    tb_wdata = 8'h00; tb_drive = 1'b0; tb_rxd = 1'b1; loop_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_tbr", {31'd0, bus.tbr}, 32'd1);
    check("reset_rda", {31'd0, bus.rda}, 32'd0);

    // Register table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else            read_check(vecs[i].name, vecs[i].addr, vecs[i].data);
    end

    // Reset in the middle of a frame's start bit (div = 3)
    bus_write(2'b00, 8'h5A);
    t = 0;
    while (txd !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    check("midframe_start_seen", {31'd0, txd}, 32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midframe_rst_txd", {31'd0, txd}, 32'd1);
    check("midframe_rst_tbr", {31'd0, bus.tbr}, 32'd1);
    check("midframe_rst_rda", {31'd0, bus.rda}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    read_check("midframe_status", 2'b01, 8'h06);
    read_check("midframe_div_lo", 2'b10, 8'hA2);
    read_check("midframe_div_hi", 2'b11, 8'h00);

    // Loopback at div = 3
    bus_write(2'b10, 8'h03);
    loop_en = 1'b1;
    bus_write(2'b00, 8'h55);
    bus_write(2'b00, 8'hA3);
    bus_write(2'b00, 8'h00);
    repeat (2200) @(negedge clk);
    read_check("loop_status", 2'b01, 8'h07);
    read_check("loop_byte0", 2'b00, 8'h55);
    read_check("loop_byte1", 2'b00, 8'hA3);
    read_check("loop_byte2", 2'b00, 8'h00);
    read_check("loop_status_after", 2'b01, 8'h06);
    loop_en = 1'b0;

    // Fill TX at div = 0xFFFF, then release at div = 0 and count frames
    bus_write(2'b11, 8'hFF);
    bus_write(2'b10, 8'hFF);
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(2'b00, 8'(8'h10 + i));
      if (i == DEPTH - 2) check("fill_tbr_before_full", {31'd0, bus.tbr}, 32'd1);
      if (i == DEPTH - 1) check("fill_tbr_full", {31'd0, bus.tbr}, 32'd0);
    end
    bus_write(2'b00, 8'hEE);
    read_check("fill_status_full", 2'b01, 8'h00);
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      tx_capture(OS, d, ok);
      check($sformatf("fill_frame_ok_%0d", i), {31'd0, ok}, 32'd1);
      check($sformatf("fill_frame_data_%0d", i), {24'd0, d}, {24'd0, 8'(8'h10 + i)});
    end
    lows = 0;
    for (int i = 0; i < 30 * OS; i++) begin
      @(negedge clk);
      if (txd === 1'b0) lows++;
    end
    check("fill_no_extra_frame", lows, 0);
    read_check("fill_status_idle", 2'b01, 8'h06);

    // RX overrun: DEPTH+1 frames, no reads (div = 0)
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i * 37 + 5), 1'b1, OS);
    repeat (40) @(negedge clk);
    check("ovr_rda", {31'd0, bus.rda}, 32'd1);
    read_check("ovr_status", 2'b01, 8'h1F);
    read_check("ovr_status_cleared", 2'b01, 8'h0F);
    for (int i = 0; i < DEPTH; i++)
      read_check($sformatf("ovr_byte_%0d", i), 2'b00, 8'(i * 37 + 5));
    read_check("ovr_empty_read", 2'b00, 8'h00);
    read_check("ovr_status_end", 2'b01, 8'h06);

    // Framing error: stop bit low
    send_frame(8'h5A, 1'b0, OS);
    repeat (40) @(negedge clk);
    check("ferr_rda", {31'd0, bus.rda}, 32'd0);
    read_check("ferr_status", 2'b01, 8'h26);
    read_check("ferr_status_cleared", 2'b01, 8'h06);

    // One-tick glitch on rxd, then a good frame to show the receiver recovered
    @(negedge clk); tb_rxd = 1'b0;
    @(negedge clk); tb_rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_rda", {31'd0, bus.rda}, 32'd0);
    read_check("glitch_status", 2'b01, 8'h06);
    send_frame(8'hC3, 1'b1, OS);
    repeat (40) @(negedge clk);
    read_check("glitch_recover_byte", 2'b00, 8'hC3);

    // 0x01 followed by a 0 bit (bad parity) and a 1 bit
    send_bits({1'b1, 1'b0, 8'h01, 1'b0}, 11, OS);
    repeat (40) @(negedge clk);
`ifdef SPART_PARITY_EN
    read_check("par_status", 2'b01, 8'h47);
    read_check("par_byte", 2'b00, 8'h01);
`else
    check("par_rda", {31'd0, bus.rda}, 32'd0);
    read_check("par_status", 2'b01, 8'h26);
`endif
    read_check("par_status_end", 2'b01, 8'h06);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spart_fifo.md
# spart_fifo

Buffered, parametrised SPART: a drop-in successor to the single-byte SPART on the same 2-bit-address, 8-bit tri-state processor bus, adding TX/RX FIFOs of configurable depth, a runtime-programmable baud divisor with configurable oversampling, and sticky line-error flags. It sits between the CPU I/O bus and the board's RS-232 pins. It fully replaces the single-byte block at the same address window.

## Interface
- `RX_DEPTH`, 16: RX FIFO entries; power of 2, ≥2.
- `TX_DEPTH`, 16: TX FIFO entries; power of 2, ≥2.
- `OVERSAMPLE`, 16: baud ticks per bit; even, ≥4.
- `DIV_RESET`, 16'd162: reset value of the 16-bit divisor.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `iocs` in 1: chip select; qualifies every access.
- `iorw` in 1: 1 = read, 0 = write.
- `ioaddr` in 2: register select.
- `databus` inout 8: tri-state processor bus.
- `rda` out 1: RX FIFO non-empty.
- `tbr` out 1: TX FIFO not full.
- `txd` out 1: serial out, idles high.
- `rxd` in 1: serial in, asynchronous to `clk`.

## Operation
- Register map:
  - 00: read pops RX; write pushes TX.
  - 01: read returns status; write is ignored.
  - 10: R/W divisor low byte.
  - 11: R/W divisor high byte.
- Bus drive: `databus` is driven only while `iocs & iorw`; otherwise Z.
- An access is one `clk` cycle. Holding `iocs` for N cycles performs N accesses.
- Status byte:
  - [0] `rda`, [1] `tbr`.
  - [2] tx_idle: TX FIFO empty and shifter idle.
  - [3] rx_full.
  - [4] overrun, [5] framing error, [6] parity error.
  - [7] = 0.
  - [6:4] are sticky and clear on the cycle after a status read.
- Baud tick: a 16-bit down-counter reloads with the divisor and pulses one tick on reaching zero.
  - Tick rate = clk/(div+1).
  - Bit rate = tick rate / OVERSAMPLE.
  - Writing either divisor byte reloads the counter immediately.
- TX: frame is start(0), 8 data bits LSB first, optional parity, stop(1).
  - The shifter pops the FIFO when idle and the FIFO is non-empty.
  - Back-to-back frames have no idle gap.
  - A write while the TX FIFO is full is dropped silently; `tbr` already shows full.
- RX: `rxd` passes through a 2-flop synchroniser.
  - RX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE: a falling edge enters START.
  - START: sample at OVERSAMPLE/2 ticks. If high, the start is false; return to IDLE.
  - DATA: sample each bit every OVERSAMPLE ticks.
  - STOP: a stop sample of 0 sets the framing flag and discards the byte. The FSM returns to IDLE once `rxd` is high.
  - A valid byte is pushed to the RX FIFO. If the FIFO is full, the byte is dropped and overrun is set.
- RX FIFO push and pop in the same cycle: both occur and the count is unchanged. This holds even when the FIFO is full; the push is accepted.
- Read of addr 00 with the RX FIFO empty returns 0x00; no pop, no flag.
- FIFO pointers are one bit wider than the address so that full and empty are distinguishable; they wrap modulo 2·DEPTH.

## Timing
- Reset values, applied asynchronously:
  - `txd`=1, `rda`=0, `tbr`=1, `databus`=Z.
  - FIFOs empty, flags 0, divisor=DIV_RESET.
  - FSMs in IDLE; baud counter loaded.
- Reset mid-frame aborts the frame: `txd` returns high immediately and any partial RX byte is lost.
- Read data is combinational from the FIFO head or register in the access cycle. The pop or flag-clear takes effect at the closing `clk` edge.
- `rda` rises on the edge after the RX push. `tbr` falls on the edge of the push that fills the TX FIFO.
- TX start bit begins on the first baud tick after the shifter loads, and the shifter loads ≤1 cycle after a push into an idle TX path. The frame lasts 10×OVERSAMPLE ticks, or 11×OVERSAMPLE with parity.
- RX push occurs at the stop-bit sample plus 1 cycle.

## Configuration
- `SPART_PARITY_EN` defined:
  - TX inserts an even-parity bit after D7.
  - RX checks that bit; on mismatch it sets status[6] and still pushes the byte.
  - The frame is 11 bits.
- `SPART_PARITY_EN` undefined:
  - 8N1 frames only.
  - status[6] is constant 0.
  - No parity logic is synthesised.

## Test plan
- Reset: assert `rst` mid-TX frame → `txd`=1, `tbr`=1, `rda`=0, status reads 0x06, divisor reads 162 (0xA2/0x00).
- Loopback (`txd`→`rxd`), div=3, write 0x55, 0xA3, 0x00 → three reads of addr 00 return 0x55, 0xA3, 0x00 in order, with no status errors.
- Fill TX with TX_DEPTH+1 writes at div=0xFFFF → `tbr`=0 after write TX_DEPTH; the extra write is lost; exactly TX_DEPTH frames appear on `txd`.
- Drive RX_DEPTH+1 frames with no reads → rx_full=1 and overrun=1; reads return the first RX_DEPTH bytes. The status read after the first one returns overrun=0.
- Drive a frame with stop=0 → framing flag set, nothing pushed, `rda` stays 0. A 1-tick low glitch on `rxd` → no frame, no flag.
- With `SPART_PARITY_EN`, drive 0x01 with parity bit 0 → byte 0x01 pushed and status[6]=1. Without the macro, the same stimulus yields a framing error.
